// File: rtl/register_file_if.sv
// -----------------------------------------------------------------------------
// register_file_if
// Bus bundle between the datapath and register_file.
//   read_reg_one / read_reg_two : rs / rt read indices (master -> slave)
//   reg_one / reg_two           : rs / rt read data     (slave -> master)
//   reg_write / write_reg / write_data : writeback port (master -> slave)
//   clear_req                   : start a clear sweep   (master -> slave)
//   busy                        : sweep in progress     (slave -> master)
// -----------------------------------------------------------------------------
interface register_file_if #(
  parameter int DATA_WIDTH = 19,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] read_reg_one;
  logic [ADDR_WIDTH-1:0] read_reg_two;
  logic [DATA_WIDTH-1:0] reg_one;
  logic [DATA_WIDTH-1:0] reg_two;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  clear_req;
  logic                  busy;

  modport master (
    output read_reg_one, read_reg_two, reg_write, write_reg, write_data, clear_req,
    input  reg_one, reg_two, busy
  );

  modport slave (
    input  read_reg_one, read_reg_two, reg_write, write_reg, write_data, clear_req,
    output reg_one, reg_two, busy
  );
endinterface

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 8 x 19-bit general-purpose register file feeding the ALU operands.
// Two combinational read ports, one synchronous write port, and a sequenced
// clear engine that zeroes R1..R7 one register per cycle.
//
// Ports:
//   i_clk : clock, all state updates on the rising edge
//   i_rst : synchronous active-high reset
//   bus   : register_file_if.slave (read indices/data, writeback, clear_req, busy)
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-through forwarding of write_data onto matching read ports
//   undefined -> read ports show stored contents only
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 19,
  parameter int ADDR_WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  register_file_if.slave   bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // R0 has no storage: it is hardwired zero on the read side.
  logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  w_clr_en;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_reg_one;
  logic [DATA_WIDTH-1:0] w_reg_two;

  // Writes are dropped while sweeping and never land on R0.
  assign w_wr_en = bus.reg_write & ~r_busy & (bus.write_reg != '0);

  // Clear FSM state, sweep counter and registered busy flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Clear FSM next-state logic; busy is derived from the next state so it
  // stays registered and clear_req never reaches an output combinationally.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_clr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = ADDR_WIDTH'(1);
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      CLEAR: begin
        w_clr_en  = 1'b1;
        // Counter wraps back to 0 after clearing the last index.
        w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = CLEAR;
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Register storage: reset, writeback, or sweep clear (never both in one
  // cycle, since writes require busy=0 and clears only happen in CLEAR).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_wr_en && (bus.write_reg == ADDR_WIDTH'(i))) begin
          r_regs[i] <= bus.write_data;
        end else if (w_clr_en && (r_cnt == ADDR_WIDTH'(i))) begin
          r_regs[i] <= '0;
        end else begin
          r_regs[i] <= r_regs[i];
        end
      end
    end
  end

  // Combinational read ports; index 0 falls through to zero.
  always_comb begin
    w_reg_one = '0;
    w_reg_two = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_reg_one = (bus.read_reg_one == ADDR_WIDTH'(i)) ? r_regs[i] : w_reg_one;
      w_reg_two = (bus.read_reg_two == ADDR_WIDTH'(i)) ? r_regs[i] : w_reg_two;
    end
`ifdef REGFILE_BYPASS_EN
    // Write-through: w_wr_en already excludes index 0 and busy.
    w_reg_one = (w_wr_en && (bus.write_reg == bus.read_reg_one)) ? bus.write_data : w_reg_one;
    w_reg_two = (w_wr_en && (bus.write_reg == bus.read_reg_two)) ? bus.write_data : w_reg_two;
`else
    w_reg_one = w_reg_one;
    w_reg_two = w_reg_two;
`endif
  end

  assign bus.reg_one = w_reg_one;
  assign bus.reg_two = w_reg_two;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Directed, table-driven bench for register_file plus hand-written sequences
// for the clear sweep, write-during-busy and reset-mid-sweep cases.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int DW = 19;
  localparam int AW = 3;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.reg_write  = 1'b1;
    bus_if.write_reg  = a;
    bus_if.write_data = d;
    tick();
    bus_if.reg_write  = 1'b0;
  endtask

  logic [DW-1:0] exp_byp;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_if.read_reg_one = '0;
    bus_if.read_reg_two = '0;
    bus_if.reg_write    = 1'b0;
    bus_if.write_reg    = '0;
    bus_if.write_data   = '0;
    bus_if.clear_req    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    bus_if.read_reg_one = 3'd3;
    bus_if.read_reg_two = 3'd5;
    #1;
    chk("reset_busy", {18'd0, bus_if.busy}, 19'd0);
    chk("reset_one",  bus_if.reg_one, 19'd0);
    chk("reset_two",  bus_if.reg_two, 19'd0);

    // {wr, waddr, wdata, ra1, ra2, exp1, exp2}: expectations after the edge
    vecs[0] = '{1'b1, 3'd0, 19'h7FFFF, 3'd0, 3'd0, 19'h00000, 19'h00000};
    vecs[1] = '{1'b1, 3'd3, 19'h12345, 3'd3, 3'd0, 19'h12345, 19'h00000};
    vecs[2] = '{1'b1, 3'd5, 19'h00F0F, 3'd3, 3'd5, 19'h12345, 19'h00F0F};
    vecs[3] = '{1'b1, 3'd2, 19'h00001, 3'd2, 3'd2, 19'h00001, 19'h00001};
    vecs[4] = '{1'b1, 3'd7, 19'h7FFFF, 3'd7, 3'd3, 19'h7FFFF, 19'h12345};
    vecs[5] = '{1'b0, 3'd4, 19'h2AAAA, 3'd5, 3'd4, 19'h00F0F, 19'h00000};
    vecs[6] = '{1'b1, 3'd3, 19'h00ABC, 3'd3, 3'd5, 19'h00ABC, 19'h00F0F};

    for (int v = 0; v < 7; v++) begin
      bus_if.reg_write    = vecs[v].wr;
      bus_if.write_reg    = vecs[v].waddr;
      bus_if.write_data   = vecs[v].wdata;
      bus_if.read_reg_one = vecs[v].ra1;
      bus_if.read_reg_two = vecs[v].ra2;
      tick();
      bus_if.reg_write = 1'b0;
      #1;
      chk($sformatf("vec%0d_one", v), bus_if.reg_one, vecs[v].exp1);
      chk($sformatf("vec%0d_two", v), bus_if.reg_two, vecs[v].exp2);
    end
    chk("r0_busy", {18'd0, bus_if.busy}, 19'd0);

    // Bypass: R2 holds 1, write 40000 to R2 while reading it on both ports.
`ifdef REGFILE_BYPASS_EN
    exp_byp = 19'h40000;
`else
    exp_byp = 19'h00001;
`endif
    bus_if.read_reg_one = 3'd2;
    bus_if.read_reg_two = 3'd2;
    bus_if.reg_write    = 1'b1;
    bus_if.write_reg    = 3'd2;
    bus_if.write_data   = 19'h40000;
    #1;
    chk("byp_pre_one", bus_if.reg_one, exp_byp);
    chk("byp_pre_two", bus_if.reg_two, exp_byp);
    tick();
    bus_if.reg_write = 1'b0;
    #1;
    chk("byp_post_one", bus_if.reg_one, 19'h40000);
    chk("byp_post_two", bus_if.reg_two, 19'h40000);

    // Clear sweep with write and second clear_req during busy.
    for (int k = 1; k < 8; k++) wr(AW'(k), 19'h01000 + DW'(k));
    bus_if.read_reg_one = 3'd4;
    bus_if.read_reg_two = 3'd1;
    #1;
    chk("pre_sweep_r4", bus_if.reg_one, 19'h01004);
    chk("pre_sweep_r1", bus_if.reg_two, 19'h01001);
    bus_if.clear_req = 1'b1;
    tick();                       // edge E
    bus_if.clear_req = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      // state after edge E+k
      chk($sformatf("sweep_busy_e%0d", k), {18'd0, bus_if.busy}, (k <= 6) ? 19'd1 : 19'd0);
      chk($sformatf("sweep_r4_e%0d", k), bus_if.reg_one, (k < 4) ? 19'h01004 : 19'h00000);
      chk($sformatf("sweep_r1_e%0d", k), bus_if.reg_two, (k < 1) ? 19'h01001 : 19'h00000);
      if (k == 2) begin
        bus_if.reg_write  = 1'b1;
        bus_if.write_reg  = 3'd1;
        bus_if.write_data = 19'h55555;
        bus_if.clear_req  = 1'b1;
      end else begin
        bus_if.reg_write  = 1'b0;
        bus_if.clear_req  = 1'b0;
      end
      tick();
    end
    bus_if.reg_write = 1'b0;
    bus_if.clear_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_if.read_reg_one = AW'(i);
      #1;
      chk($sformatf("post_sweep_r%0d", i), bus_if.reg_one, 19'd0);
    end
    // First write after the sweep is accepted.
    wr(3'd6, 19'h00777);
    bus_if.read_reg_one = 3'd6;
    #1;
    chk("post_sweep_wr", bus_if.reg_one, 19'h00777);

    // Reset mid-sweep.
    wr(3'd5, 19'h3C3C3);
    wr(3'd7, 19'h11111);
    bus_if.clear_req = 1'b1;
    tick();                       // edge E
    bus_if.clear_req = 1'b0;
    tick();                       // edge E+1
    rst = 1'b1;
    tick();                       // edge E+2 with reset
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", {18'd0, bus_if.busy}, 19'd0);
    for (int i = 0; i < 8; i++) begin
      bus_if.read_reg_one = AW'(i);
      #1;
      chk($sformatf("rst_mid_r%0d", i), bus_if.reg_one, 19'd0);
    end
    tick();
    chk("rst_mid_busy_stays", {18'd0, bus_if.busy}, 19'd0);
    wr(3'd6, 19'h0ABCD);
    bus_if.read_reg_one = 3'd6;
    bus_if.read_reg_two = 3'd6;
    #1;
    chk("rst_mid_wr_one", bus_if.reg_one, 19'h0ABCD);
    chk("rst_mid_wr_two", bus_if.reg_two, 19'h0ABCD);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
